// File: rtl/pipeline_pkg.sv
// Shared encodings for the MEM stage: funct3 access codes, FSM states and byte-enable patterns,
// plus small decode helpers used by both the stage controller and the lane aligner.
package pipeline_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    function automatic access_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            F3_W:        return SZ_WORD;
            // Reserved codes fall back to a full-word access.
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3_size(f3))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane aligner: store byte enables and lane replication on the request side,
// byte/half extraction with sign or zero extension on the response side.
module lsu_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_ld_unsigned;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane[gi] = ld_word[8*gi +: 8];
    end

    assign w_byte        = w_lane[ld_addr_lo];
    assign w_half        = ld_addr_lo[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};
    assign w_ld_unsigned = f3_unsigned(ld_funct3);

    always_comb begin
        st_be    = BE_WORD;
        st_wdata = st_data;
        case (f3_size(st_funct3))
            SZ_BYTE: begin
                st_be    = BE_BYTE << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = BE_HALF << st_addr_lo;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = BE_WORD;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_data = ld_word;
        case (f3_size(ld_funct3))
            SZ_BYTE: ld_data = {{24{w_byte[7] & ~w_ld_unsigned}}, w_byte};
            SZ_HALF: ld_data = {{16{w_half[15] & ~w_ld_unsigned}}, w_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store over a req/ready handshake,
// stalls upstream stages until completion or timeout, and hands aligned results to MEM/WB.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic        regwrite_in,
    input  logic        memtoreg_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] aluresult_in,
    input  logic [31:0] writedata_in,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_misaligned,
    output logic        bus_error,
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic [31:0] readdata_out,
    output logic [31:0] aluresult_out,
    output logic [4:0]  rd_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_we;
    logic [29:0]      r_addr_word;
    logic [1:0]       r_addr_lo;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [2:0]       r_funct3;
    logic             r_is_load;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic [1:0]  w_state_next;
    logic        w_in_idle;
    logic        w_in_wait;
    logic        w_in_done;
    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_start;
    logic        w_timeout;
    logic        w_stall;
    logic        w_mis_flag;
    logic        w_berr;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;

    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_in_wait    = (r_state == ST_WAIT);
    assign w_in_done    = (r_state == ST_DONE);
    assign w_mem_op     = memread_in | memwrite_in;
    assign w_misaligned = is_misaligned(funct3_in, aluresult_in[1:0]);
    assign w_start      = w_in_idle & w_mem_op & ~w_misaligned;
    assign w_timeout    = (r_count == CNT_LAST);

    assign w_stall    = w_start | w_in_wait;
    assign w_mis_flag = w_in_idle & w_mem_op & w_misaligned;
    assign w_berr     = w_in_done & r_err;

    // Store alignment uses the live EX/MEM fields; load extraction uses the fields latched at issue.
    lsu_align u_align (
        .st_funct3  (funct3_in),
        .st_addr_lo (aluresult_in[1:0]),
        .st_data    (writedata_in),
        .st_be      (w_st_be),
        .st_wdata   (w_st_wdata),
        .ld_funct3  (r_funct3),
        .ld_addr_lo (r_addr_lo),
        .ld_word    (dmem_rdata),
        .ld_data    (w_ld_data)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_WAIT;
            ST_WAIT: if (dmem_ready || w_timeout) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_we        <= 1'b0;
            r_addr_word <= '0;
            r_addr_lo   <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_is_load   <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_count     <= '0;
                r_we        <= memwrite_in;
                r_addr_word <= aluresult_in[31:2];
                r_addr_lo   <= aluresult_in[1:0];
                r_be        <= w_st_be;
                r_wdata     <= w_st_wdata;
                r_funct3    <= funct3_in;
                r_is_load   <= memread_in & ~memwrite_in;
                r_rdata     <= '0;
                r_err       <= 1'b0;
            end
            if (w_in_wait) begin
                // A ready arriving on the last allowed cycle still completes cleanly.
                if (dmem_ready) begin
                    r_rdata <= r_is_load ? w_ld_data : '0;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_be        = '0;
        dmem_wdata     = '0;
        mem_stall      = 1'b0;
        mem_misaligned = 1'b0;
        bus_error      = 1'b0;
        regwrite_out   = 1'b0;
        memtoreg_out   = 1'b0;
        readdata_out   = '0;
        aluresult_out  = '0;
        rd_out         = '0;
        if (!rst) begin
            dmem_req       = w_in_wait;
            dmem_we        = r_we;
            dmem_addr      = {r_addr_word, 2'b00};
            dmem_be        = r_be;
            dmem_wdata     = r_wdata;
            mem_stall      = w_stall;
            mem_misaligned = w_mis_flag;
            bus_error      = w_berr;
            // Stalled, misaligned and failed accesses hand MEM/WB a bubble.
            regwrite_out   = regwrite_in & ~w_stall & ~w_mis_flag & ~w_berr;
            memtoreg_out   = memtoreg_in;
            readdata_out   = w_in_done ? r_rdata : '0;
            aluresult_out  = aluresult_in;
            rd_out         = rd_in;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues ops and pushes expected results,
// a responder models memory latency, and two monitors check retirements and bus requests.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        memread_in;
    logic        memwrite_in;
    logic        regwrite_in;
    logic        memtoreg_in;
    logic [2:0]  funct3_in;
    logic [31:0] aluresult_in;
    logic [31:0] writedata_in;
    logic [4:0]  rd_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_misaligned;
    logic        bus_error;
    logic        regwrite_out;
    logic        memtoreg_out;
    logic [31:0] readdata_out;
    logic [31:0] aluresult_out;
    logic [4:0]  rd_out;

    typedef struct {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] readdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mis;
        logic        berr;
        int          stalls;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cur_lat = 0;
    logic [31:0] cur_rdata = '0;
    logic        force_ready = 1'b0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .memread_in     (memread_in),
        .memwrite_in    (memwrite_in),
        .regwrite_in    (regwrite_in),
        .memtoreg_in    (memtoreg_in),
        .funct3_in      (funct3_in),
        .aluresult_in   (aluresult_in),
        .writedata_in   (writedata_in),
        .rd_in          (rd_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .mem_stall      (mem_stall),
        .mem_misaligned (mem_misaligned),
        .bus_error      (bus_error),
        .regwrite_out   (regwrite_out),
        .memtoreg_out   (memtoreg_out),
        .readdata_out   (readdata_out),
        .aluresult_out  (aluresult_out),
        .rd_out         (rd_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access width in bytes, load extension and store lane placement.
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        if (n == 4) return word;
        v = word >> (8 * addr[1:0]);
        v = v & ((32'd1 << (8 * n)) - 32'd1);
        if (!f3[2] && v[8*n-1]) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic req_t make_req(input logic wr, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wd);
        req_t q;
        int n;
        n = size_of(f3);
        q.we   = wr;
        q.addr = addr & ~32'h3;
        q.be   = 4'(((32'd1 << n) - 32'd1) << addr[1:0]);
        if (n == 1)      q.wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (n == 2) q.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else             q.wdata = wd;
        return q;
    endfunction

    // Called just after a rising edge; returns just after the rising edge that follows retirement.
    task automatic issue(input logic rd_en, input logic wr_en, input logic rw, input logic m2r,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input int lat, input logic [31:0] rdata);
        exp_t e;
        int   n;
        logic mem_op;
        logic mis;
        memread_in   = rd_en;
        memwrite_in  = wr_en;
        regwrite_in  = rw;
        memtoreg_in  = m2r;
        funct3_in    = f3;
        aluresult_in = addr;
        writedata_in = wd;
        rd_in        = rd;
        cur_lat      = lat;
        cur_rdata    = rdata;
        mem_op = rd_en | wr_en;
        mis    = mem_op && ((addr % size_of(f3)) != 0);
        e.regwrite = rw;
        e.memtoreg = m2r;
        e.readdata = '0;
        e.alu      = addr;
        e.rd       = rd;
        e.mis      = 1'b0;
        e.berr     = 1'b0;
        e.stalls   = 0;
        if (mem_op && mis) begin
            e.regwrite = 1'b0;
            e.mis      = 1'b1;
        end else if (mem_op) begin
            req_q.push_back(make_req(wr_en, f3, addr, wd));
            if (lat < TO) begin
                e.stalls = lat + 2;
                if (rd_en) e.readdata = ref_load(f3, addr, rdata);
            end else begin
                e.stalls   = 1 + TO;
                e.regwrite = 1'b0;
                e.berr     = 1'b1;
            end
        end
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_stall && n < 50);
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL op_timeout: stall still 1 after %0d cycles, required release", n);
        end
        @(posedge clk);
        #1;
    endtask

    // Memory responder: ready after cur_lat WAIT cycles, random noise on ready while idle.
    initial begin : responder
        int wait_n;
        wait_n     = 0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (dmem_req) begin
                dmem_ready = (wait_n == cur_lat);
                dmem_rdata = dmem_ready ? cur_rdata : $urandom;
                wait_n++;
            end else begin
                wait_n     = 0;
                dmem_ready = force_ready | ($urandom_range(0, 1) == 1);
                dmem_rdata = $urandom;
            end
        end
    end

    // Retirement monitor: every unstalled, non-reset cycle hands one op to MEM/WB.
    initial begin : retire_mon
        int   stall_run;
        exp_t e;
        stall_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs",
                    64'({dmem_req, dmem_we, dmem_be, mem_stall, mem_misaligned, bus_error,
                         regwrite_out, memtoreg_out, rd_out, |dmem_addr, |dmem_wdata,
                         |readdata_out, |aluresult_out}), 64'd0);
                stall_run = 0;
                continue;
            end
            if (mem_stall) begin
                stall_run++;
                chk("flags_in_stall", 64'({mem_misaligned, bus_error}), 64'd0);
            end else if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_retire: got retire rd=%0d, required none", rd_out);
            end else begin
                e = exp_q.pop_front();
                chk("regwrite_out",   64'(regwrite_out),   64'(e.regwrite));
                chk("memtoreg_out",   64'(memtoreg_out),   64'(e.memtoreg));
                chk("readdata_out",   64'(readdata_out),   64'(e.readdata));
                chk("aluresult_out",  64'(aluresult_out),  64'(e.alu));
                chk("rd_out",         64'(rd_out),         64'(e.rd));
                chk("mem_misaligned", 64'(mem_misaligned), 64'(e.mis));
                chk("bus_error",      64'(bus_error),      64'(e.berr));
                chk("stall_cycles",   64'(stall_run),      64'(e.stalls));
                $display("[TB] retire rd=%0d alu=0x%08h data=0x%08h rw=%0b mis=%0b berr=%0b stalls=%0d",
                         rd_out, aluresult_out, readdata_out, regwrite_out, mem_misaligned,
                         bus_error, stall_run);
                stall_run = 0;
            end
        end
    end

    // Request monitor: fields must match the expected request for every cycle req is high.
    initial begin : req_mon
        logic prev;
        req_t q;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                continue;
            end
            if (prev && !dmem_req && req_q.size() > 0) void'(req_q.pop_front());
            if (dmem_req) begin
                if (req_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: got dmem_req=1 addr=0x%08h, required 0", dmem_addr);
                end else begin
                    q = req_q[0];
                    chk("dmem_we",   64'(dmem_we),   64'(q.we));
                    chk("dmem_addr", 64'(dmem_addr), 64'(q.addr));
                    chk("dmem_be",   64'(dmem_be),   64'(q.be));
                    if (q.we) chk("dmem_wdata", 64'(dmem_wdata), 64'(q.wdata));
                end
            end
            prev = dmem_req;
        end
    end

    initial begin : driver
        logic [2:0]  f3;
        logic [31:0] addr;
        int          kind;
        rst          = 1'b1;
        memread_in   = 1'b1;
        memwrite_in  = 1'b0;
        regwrite_in  = 1'b1;
        memtoreg_in  = 1'b1;
        funct3_in    = 3'b010;
        aluresult_in = 32'hFFFF_FFF0;
        writedata_in = 32'h1234_5678;
        rd_in        = 5'd31;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 5'd1, 0, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h103, 32'h0, 5'd2, 0, 32'h80FF_FFFF);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 32'h103, 32'h0, 5'd3, 1, 32'h80FF_FFFF);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h102, 32'h0000_ABCD, 5'd0, 0, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h101, 32'h0, 5'd4, 0, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h104, 32'h0, 5'd5, 99, 32'h1234_5678);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 32'h106, 32'h0, 5'd6, 3, 32'h8001_7FFF);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'hCAFE_0001, 32'h0, 5'd7, 0, 32'h0);

        // Reset while the second WAIT cycle of a load is in progress.
        memread_in   = 1'b1;
        memwrite_in  = 1'b0;
        regwrite_in  = 1'b1;
        memtoreg_in  = 1'b1;
        funct3_in    = 3'b010;
        aluresult_in = 32'h200;
        writedata_in = 32'h0;
        rd_in        = 5'd8;
        cur_lat      = 1000;
        req_q.push_back(make_req(1'b0, 3'b010, 32'h200, 32'h0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        req_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        force_ready = 1'b1;
        issue(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h300, 32'h0, 5'd9, 0, 32'h0);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h304, 32'h0, 5'd10, 0, 32'h0);
        force_ready = 1'b0;

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            if (kind < 2) begin
                f3 = 3'($urandom_range(0, 7));
                issue(1'b0, 1'b0, 1'($urandom), 1'($urandom), f3, addr, $urandom,
                      5'($urandom), 0, 32'h0);
            end else if (kind < 6) begin
                f3 = 3'($urandom_range(0, 7));
                issue(1'b1, 1'b0, 1'($urandom), 1'($urandom), f3, addr, $urandom,
                      5'($urandom), $urandom_range(0, 5), $urandom);
            end else begin
                f3 = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'($urandom_range(0, 2));
                issue(1'b0, 1'b1, 1'($urandom), 1'($urandom), f3, addr, $urandom,
                      5'($urandom), $urandom_range(0, 5), $urandom);
            end
        end

        chk("queues_drained", 64'(exp_q.size() + req_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
